// File: rtl/udma_filter_addrgen.sv
// udma_filter_addrgen
// Address generator for one uDMA filter stream channel. Latches a job
// description on a start pulse, then walks linear, 2D-strided or repeated
// address patterns over a valid/ready handshake and pulses done at the end.

module udma_filter_addrgen #(
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int TRANS_SIZE     = 15
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_start_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
  output logic                      addr_valid_o,
  input  logic                      addr_ready_i,
  output logic [L2_AWIDTH_NOAL-1:0] addr_o,
  output logic [1:0]                datasize_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // latched job description
  logic [L2_AWIDTH_NOAL-1:0] start_addr_q;
  logic [1:0]                datasize_q;
  logic [1:0]                mode_q;
  logic [TRANS_SIZE-1:0]     len0_q;
  logic [TRANS_SIZE-1:0]     len1_q;
  logic [TRANS_SIZE-1:0]     len2_q;

  // walk state
  logic [TRANS_SIZE-1:0]     col_q;
  logic [TRANS_SIZE-1:0]     row_q;
  logic [L2_AWIDTH_NOAL-1:0] addr_q;
  logic [L2_AWIDTH_NOAL-1:0] rbase_q;
  logic                      done_q;

  // control strobes from the FSM
  logic done_d;
  logic latch_cfg;
  logic beat_fire;

  // derived decode
  logic                      mode_strided;
  logic                      mode_repeat;
  logic                      mode_linear;
  logic                      col_last;
  logic                      row_last;
  logic                      job_last;
  logic                      cfg_zero_len;
  logic [L2_AWIDTH_NOAL-1:0] inc;
  logic [L2_AWIDTH_NOAL-1:0] stride;
  logic [L2_AWIDTH_NOAL-1:0] rbase_next;

  assign mode_strided = (mode_q == 2'd1);
  assign mode_repeat  = (mode_q == 2'd2);
  assign mode_linear  = !(mode_strided || mode_repeat);

  assign col_last = (col_q == (len0_q - TRANS_SIZE'(1)));
  assign row_last = (row_q == (len1_q - TRANS_SIZE'(1)));
  assign job_last = col_last && (mode_linear || row_last);

  // a job with no beats never enters RUN; only the incoming fields matter here
  assign cfg_zero_len = (cfg_len0_i == '0) ||
                        (((cfg_mode_i == 2'd1) || (cfg_mode_i == 2'd2)) && (cfg_len1_i == '0));

  assign stride     = L2_AWIDTH_NOAL'(len2_q);
  assign rbase_next = rbase_q + stride;

  // element byte increment from the (already clamped) datasize
  always_comb begin
    inc = L2_AWIDTH_NOAL'(4);
    case (datasize_q)
      2'd0:    inc = L2_AWIDTH_NOAL'(1);
      2'd1:    inc = L2_AWIDTH_NOAL'(2);
      default: inc = L2_AWIDTH_NOAL'(4);
    endcase
  end

  // state and done-pulse registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // next-state, strobes and handshake outputs; valid depends on state only
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    latch_cfg    = 1'b0;
    beat_fire    = 1'b0;
    addr_valid_o = 1'b0;
    busy_o       = 1'b0;
    last_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          latch_cfg = 1'b1;
          if (cfg_zero_len) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        addr_valid_o = 1'b1;
        busy_o       = 1'b1;
        last_o       = job_last;
        if (addr_ready_i) begin
          beat_fire = 1'b1;
          if (job_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // job latch and address walk; a start seen during RUN is never latched
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_addr_q <= '0;
      datasize_q   <= '0;
      mode_q       <= '0;
      len0_q       <= '0;
      len1_q       <= '0;
      len2_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      rbase_q      <= '0;
    end else if (latch_cfg) begin
      start_addr_q <= cfg_start_addr_i;
      datasize_q   <= (cfg_datasize_i == 2'd3) ? 2'd2 : cfg_datasize_i;
      mode_q       <= cfg_mode_i;
      len0_q       <= cfg_len0_i;
      len1_q       <= cfg_len1_i;
      len2_q       <= cfg_len2_i;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= cfg_start_addr_i;
      rbase_q      <= cfg_start_addr_i;
    end else if (beat_fire) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + TRANS_SIZE'(1);
        if (!job_last) begin
          if (mode_strided) begin
            rbase_q <= rbase_next;
            addr_q  <= rbase_next;
          end else if (mode_repeat) begin
            addr_q <= start_addr_q;
          end
        end
      end else begin
        col_q  <= col_q + TRANS_SIZE'(1);
        addr_q <= addr_q + inc;
      end
    end
  end

  assign addr_o     = addr_q;
  assign datasize_o = datasize_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_udma_filter_addrgen.sv
// tb_udma_filter_addrgen
// Directed bench with a scoreboard of expected beats built from a bench-side
// model of the address patterns, compared as the DUT hands out beats.

module tb_udma_filter_addrgen;

  localparam int AW = 15;
  localparam int TS = 15;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk_i;
  logic          rstn_i;
  logic          cfg_start_i;
  logic [AW-1:0] cfg_start_addr_i;
  logic [1:0]    cfg_datasize_i;
  logic [1:0]    cfg_mode_i;
  logic [TS-1:0] cfg_len0_i;
  logic [TS-1:0] cfg_len1_i;
  logic [TS-1:0] cfg_len2_i;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic [AW-1:0] addr_o;
  logic [1:0]    datasize_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
    logic [1:0]    ds;
  } beat_t;

  beat_t expQ[$];
  int    checks;
  int    errors;

  udma_filter_addrgen #(
    .L2_AWIDTH_NOAL(AW),
    .TRANS_SIZE    (TS)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .cfg_start_i     (cfg_start_i),
    .cfg_start_addr_i(cfg_start_addr_i),
    .cfg_datasize_i  (cfg_datasize_i),
    .cfg_mode_i      (cfg_mode_i),
    .cfg_len0_i      (cfg_len0_i),
    .cfg_len1_i      (cfg_len1_i),
    .cfg_len2_i      (cfg_len2_i),
    .addr_valid_o    (addr_valid_o),
    .addr_ready_i    (addr_ready_i),
    .addr_o          (addr_o),
    .datasize_o      (datasize_o),
    .last_o          (last_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  // free-running clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulse a start and queue the beats the job should produce
  task automatic applyStimulus(input int sAddr, input int ds, input int mode,
                               input int len0, input int len1, input int len2);
    int rows;
    int incr;
    int base;
    beat_t b;
    cfg_start_addr_i = AW'(sAddr);
    cfg_datasize_i   = 2'(ds);
    cfg_mode_i       = 2'(mode);
    cfg_len0_i       = TS'(len0);
    cfg_len1_i       = TS'(len1);
    cfg_len2_i       = TS'(len2);
    rows = (mode == 1 || mode == 2) ? len1 : 1;
    incr = (ds >= 2) ? 4 : (1 << ds);
    if (len0 > 0) begin
      for (int r = 0; r < rows; r++) begin
        base = (mode == 1) ? (sAddr + r * len2) : sAddr;
        for (int c = 0; c < len0; c++) begin
          b.addr = AW'((base + c * incr) & AMASK);
          b.last = (c == len0 - 1) && (r == rows - 1);
          b.ds   = (ds >= 2) ? 2'd2 : 2'(ds);
          expQ.push_back(b);
        end
      end
    end
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
  endtask

  // consume queued beats; pattern 0 = ready high, 1 = ready 1-0-1-0;
  // midStart >= 0 fires a conflicting start on that cycle
  task automatic drainJob(input string tag, input int pattern, input int midStart);
    int  i;
    int  acc;
    int  total;
    bit  fin;
    i     = 0;
    acc   = 0;
    fin   = 1'b0;
    total = expQ.size();
    while (!fin && i < 200) begin
      addr_ready_i = (pattern == 0) ? 1'b1 : ((i % 2) == 0);
      if (i == midStart) begin
        cfg_start_i      = 1'b1;
        cfg_start_addr_i = AW'(16'h0555);
        cfg_mode_i       = 2'd0;
        cfg_datasize_i   = 2'd0;
        cfg_len0_i       = TS'(7);
      end
      checkOutput({tag, "_valid"}, 32'(addr_valid_o), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (expQ.size() > 0) begin
        checkOutput({tag, "_addr"}, 32'(addr_o), 32'(expQ[0].addr));
        checkOutput({tag, "_last"}, 32'(last_o), 32'(expQ[0].last));
        checkOutput({tag, "_ds"}, 32'(datasize_o), 32'(expQ[0].ds));
        if (addr_ready_i) begin
          void'(expQ.pop_front());
          acc++;
          if (expQ.size() == 0) fin = 1'b1;
        end
      end else begin
        fin = 1'b1;
      end
      tick();
      cfg_start_i = 1'b0;
      i++;
    end
    addr_ready_i = 1'b0;
    checkOutput({tag, "_finished_in_budget"}, 32'(fin), 32'd1);
    checkOutput({tag, "_accepted"}, 32'(acc), 32'(total));
    checkOutput({tag, "_done_pulse"}, 32'(done_o), 32'd1);
    checkOutput({tag, "_end_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_end_valid"}, 32'(addr_valid_o), 32'd0);
    tick();
    checkOutput({tag, "_done_cleared"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_stay_idle"}, 32'(addr_valid_o), 32'd0);
  endtask

  // directed sequence
  initial begin
    checks           = 0;
    errors           = 0;
    rstn_i           = 1'b0;
    cfg_start_i      = 1'b0;
    cfg_start_addr_i = '0;
    cfg_datasize_i   = '0;
    cfg_mode_i       = '0;
    cfg_len0_i       = '0;
    cfg_len1_i       = '0;
    cfg_len2_i       = '0;
    addr_ready_i     = 1'b0;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("rst_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("rst_addr", 32'(addr_o), 32'd0);
    checkOutput("rst_ds", 32'(datasize_o), 32'd0);
    checkOutput("rst_last", 32'(last_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    rstn_i = 1'b1;
    tick();

    $display("[TB] linear job, start coinciding with final beat is ignored");
    applyStimulus(16'h0100, 2, 0, 4, 0, 0);
    drainJob("linear", 0, 3);

    $display("[TB] 2D strided job with a conflicting mid-job start");
    applyStimulus(16'h0200, 1, 1, 3, 2, 16'h0040);
    drainJob("strided", 0, 2);

    $display("[TB] repeat job with backpressure");
    applyStimulus(16'h0010, 0, 2, 2, 3, 0);
    drainJob("repeat", 1, -1);

    $display("[TB] mode 3 and datasize 3 behave as linear/word");
    applyStimulus(16'h0020, 3, 3, 2, 5, 16'h0100);
    drainJob("m3ds3", 0, -1);

    $display("[TB] zero-length jobs");
    applyStimulus(16'h0040, 2, 0, 0, 3, 0);
    checkOutput("zl0_done", 32'(done_o), 32'd1);
    checkOutput("zl0_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("zl0_busy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("zl0_done_cleared", 32'(done_o), 32'd0);
    checkOutput("zl0_valid_after", 32'(addr_valid_o), 32'd0);
    applyStimulus(16'h0040, 1, 1, 4, 0, 16'h0010);
    checkOutput("zl1_done", 32'(done_o), 32'd1);
    checkOutput("zl1_valid", 32'(addr_valid_o), 32'd0);
    tick();
    checkOutput("zl1_done_cleared", 32'(done_o), 32'd0);

    $display("[TB] address wrap");
    applyStimulus(16'h7FFE, 2, 0, 2, 0, 0);
    drainJob("wrap", 0, -1);

    $display("[TB] reset in the middle of a job");
    applyStimulus(16'h0300, 2, 0, 4, 0, 0);
    addr_ready_i = 1'b1;
    checkOutput("abort_first_addr", 32'(addr_o), 32'h300);
    tick();
    checkOutput("abort_second_addr", 32'(addr_o), 32'h304);
    rstn_i = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("abort_addr", 32'(addr_o), 32'd0);
    checkOutput("abort_ds", 32'(datasize_o), 32'd0);
    checkOutput("abort_last", 32'(last_o), 32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    expQ.delete();
    addr_ready_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_no_done", 32'(done_o), 32'd0);
      checkOutput("abort_idle", 32'(busy_o), 32'd0);
    end

    $display("[TB] recovery job after reset");
    applyStimulus(16'h0050, 0, 0, 3, 0, 0);
    drainJob("recover", 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
